// File: rtl/rr_lock_arb_if.sv
// rr_lock_arb_if: requester-side bus of the locking round-robin arbiter.
// master: enable/req/last out, gnt/valid/owner_id/timeout in.
// slave : the arbiter side of the same signals.
interface rr_lock_arb_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic           enable;
    logic [N-1:0]   req;
    logic           last;
    logic [N-1:0]   gnt;
    logic           valid;
    logic [IDW-1:0] owner_id;
    logic           timeout;

    modport master (
        output enable, req, last,
        input  gnt, valid, owner_id, timeout
    );

    modport slave (
        input  enable, req, last,
        output gnt, valid, owner_id, timeout
    );
endinterface

// File: rtl/rr_lock_arb.sv
// rr_lock_arb: registered round-robin arbiter with grant locking and hold limit.
// Ports: clk, rst (sync, active-high), bus (slave: enable/req/last in;
// gnt/valid/owner_id/timeout out, all registered).
module rr_lock_arb #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N)
) (
    input logic          clk,
    input logic          rst,
    rr_lock_arb_if.slave bus
);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
    localparam logic [N-1:0]  ONE_N    = N'(1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   prio_q, prio_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           tmo_q, tmo_d;

    logic [N-1:0]   rot;
    logic [N-1:0]   g_idle;
    logic [N-1:0]   g_rel;
    logic           rel_drop;
    logic           rel_lim;

    // First set bit at or above the pointer; else first set bit overall.
    function automatic logic [N-1:0] arb(
        input logic [N-1:0] r,
        input logic [N-1:0] p
    );
        logic [N-1:0] hi;
        logic [N-1:0] sel;
        hi  = r & ~(p - ONE_N);
        sel = (|hi) ? hi : r;
        return sel & (~sel + ONE_N);
    endfunction

    function automatic logic [IDW-1:0] enc(input logic [N-1:0] g);
        logic [IDW-1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) id = IDW'(i);
        end
        return id;
    endfunction

    // Releasing owner drops to lowest priority.
    assign rot      = {gnt_q[N-2:0], gnt_q[N-1]};
    assign g_idle   = arb(bus.req, prio_q);
    assign g_rel    = bus.enable ? arb(bus.req, rot) : '0;
    assign rel_drop = ~|(bus.req & gnt_q);
    assign rel_lim  = (hold_q == HOLD_LIM);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        prio_d  = prio_q;
        hold_d  = hold_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable && |bus.req) begin
                    gnt_d   = g_idle;
                    id_d    = enc(g_idle);
                    hold_d  = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (bus.last || rel_drop || rel_lim) begin
                    prio_d = rot;
                    tmo_d  = rel_lim & ~bus.last & ~rel_drop;
                    hold_d = '0;
                    if (|g_rel) begin
                        gnt_d   = g_rel;
                        id_d    = enc(g_rel);
                        state_d = OWN;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            prio_q  <= ONE_N;
            hold_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.valid    = |gnt_q;
    assign bus.owner_id = id_q;
    assign bus.timeout  = tmo_q;
endmodule

// File: tb/tb_rr_lock_arb.sv
// tb_rr_lock_arb: directed scoreboard bench for rr_lock_arb.
// N=4, MAX_HOLD=4; expectations queued at drive time, checked after the edge.
module tb_rr_lock_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rr_lock_arb_if #(.N(4)) bus ();

    rr_lock_arb #(
        .N(4),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       tmo;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e,
                        input logic [3:0] q, input logic l,
                        input logic [3:0] eg, input logic [1:0] eid,
                        input logic et, input string tag);
        exp_t x;
        exp_t y;
        string t;
        rst        = r;
        bus.enable = e;
        bus.req    = q;
        bus.last   = l;
        x.gnt = eg;
        x.id  = eid;
        x.tmo = et;
        exp_q.push_back(x);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        y = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".gnt"}, 32'(bus.gnt), 32'(y.gnt));
        chk({t, ".valid"}, 32'(bus.valid), 32'(|y.gnt));
        chk({t, ".id"}, 32'(bus.owner_id), 32'(y.id));
        chk({t, ".tmo"}, 32'(bus.timeout), 32'(y.tmo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b0;
        bus.req    = '0;
        bus.last   = 1'b0;
        // reset
        step(1, 0, 4'b1111, 0, 4'b0000, 0, 0, "rst0");
        step(1, 1, 4'b1111, 0, 4'b0000, 0, 0, "rst1");
        // 1: rotation by last
        step(0, 1, 4'b1111, 0, 4'b0001, 0, 0, "t1.g0");
        step(0, 1, 4'b1111, 1, 4'b0010, 1, 0, "t1.g1");
        step(0, 1, 4'b1111, 1, 4'b0100, 2, 0, "t1.g2");
        step(0, 1, 4'b1111, 1, 4'b1000, 3, 0, "t1.g3");
        step(0, 1, 4'b1111, 1, 4'b0001, 0, 0, "t1.wrap");
        // owner 0 drops req, single requester 2 takes over
        step(0, 1, 4'b0100, 0, 4'b0100, 2, 0, "t2.g");
        // 2: hold limit, self re-grant
        step(0, 1, 4'b0100, 0, 4'b0100, 2, 0, "t2.h1");
        step(0, 1, 4'b0100, 0, 4'b0100, 2, 0, "t2.h2");
        step(0, 1, 4'b0100, 0, 4'b0100, 2, 0, "t2.h3");
        step(0, 1, 4'b0100, 0, 4'b0100, 2, 1, "t2.tmo");
        step(0, 1, 4'b0100, 0, 4'b0100, 2, 0, "t2.after");
        // 3: req drop handoff, then idle
        step(0, 1, 4'b1010, 1, 4'b1000, 3, 0, "t3.g3");
        step(0, 1, 4'b1010, 1, 4'b0010, 1, 0, "t3.g1");
        step(0, 1, 4'b1000, 0, 4'b1000, 3, 0, "t3.drop");
        step(0, 1, 4'b0000, 1, 4'b0000, 3, 0, "t3.idle");
        step(0, 1, 4'b0000, 1, 4'b0000, 3, 0, "t3.lastidle");
        // 4: enable low keeps owner, blocks new grant
        step(0, 1, 4'b0100, 0, 4'b0100, 2, 0, "t4.g2");
        step(0, 0, 4'b1111, 0, 4'b0100, 2, 0, "t4.lock1");
        step(0, 0, 4'b1111, 0, 4'b0100, 2, 0, "t4.lock2");
        step(0, 0, 4'b1111, 1, 4'b0000, 2, 0, "t4.rel");
        step(0, 0, 4'b1111, 0, 4'b0000, 2, 0, "t4.off1");
        step(0, 0, 4'b1111, 0, 4'b0000, 2, 0, "t4.off2");
        step(0, 1, 4'b1111, 0, 4'b1000, 3, 0, "t4.g3");
        // 5: reset during ownership restores pointer
        step(1, 1, 4'b1111, 0, 4'b0000, 0, 0, "t5.rst");
        step(0, 1, 4'b1111, 0, 4'b0001, 0, 0, "t5.g0");
        // 6: last coincident with limit
        step(0, 1, 4'b1111, 0, 4'b0001, 0, 0, "t6.h1");
        step(0, 1, 4'b1111, 0, 4'b0001, 0, 0, "t6.h2");
        step(0, 1, 4'b1111, 0, 4'b0001, 0, 0, "t6.h3");
        step(0, 1, 4'b1111, 1, 4'b0010, 1, 0, "t6.rel");
        // timeout with handoff to next requester
        step(0, 1, 4'b1111, 0, 4'b0010, 1, 0, "t7.h1");
        step(0, 1, 4'b1111, 0, 4'b0010, 1, 0, "t7.h2");
        step(0, 1, 4'b1111, 0, 4'b0010, 1, 0, "t7.h3");
        step(0, 1, 4'b1111, 0, 4'b0100, 2, 1, "t7.tmo");
        // req drop coincident with limit
        step(0, 1, 4'b1111, 0, 4'b0100, 2, 0, "t8.h1");
        step(0, 1, 4'b1111, 0, 4'b0100, 2, 0, "t8.h2");
        step(0, 1, 4'b1111, 0, 4'b0100, 2, 0, "t8.h3");
        step(0, 1, 4'b1011, 0, 4'b1000, 3, 0, "t8.drop");
        step(0, 1, 4'b1011, 0, 4'b1000, 3, 0, "t8.after");
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rr_lock_arb.md
Name: rr_lock_arb

Overview:
- Registered round-robin arbiter with grant locking. Shares one multi-cycle resource (bus/port) among N requesters.
- Once granted, a requester keeps ownership until it signals end of transaction, drops its request, or hits a hold-time limit.
- Wraps the combinational priority-select function of the team's fixed-priority arbiters with rotating priority, grant hold and starvation protection.
- Sits between requester masters and the shared resource mux; `owner_id` drives the mux select.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant (MAX_HOLD >= 2).
- IDW, $clog2(N), width of owner_id.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  permits new grants; does not preempt a current owner.
- req  input  N  request vector; bit i = requester i.
- last  input  1  end-of-transaction strobe from the current owner.
- gnt  output  N  registered one-hot grant (all-zero when idle).
- valid  output  1  registered; equals |gnt.
- owner_id  output  IDW  binary index of the granted bit; holds last value when idle.
- timeout  output  1  one-cycle pulse: grant was revoked by the MAX_HOLD limit.

Behaviour:
- Reset (rst=1 at an edge): gnt=0, valid=0, owner_id=0, timeout=0, priority pointer=one-hot bit0, hold counter=0.
- Reset mid-ownership drops the grant at that same edge. No release bookkeeping or pointer rotation occurs.
- Arbitration function arb(r, p):
  - Grant the first set bit of r scanning upward from the one-hot position p, wrapping N-1 -> 0.
  - Result is one-hot, or zero if r = 0.
- FSM states are IDLE (gnt = 0) and OWN (gnt != 0).
- IDLE:
  - If enable and |req: next gnt = arb(req, priority), state goes to OWN, hold counter = 0.
  - Latency: req seen at edge k -> gnt high after edge k; one cycle from request to grant.
  - Otherwise remain IDLE.
- OWN, release condition at an edge (any of):
  - last = 1;
  - req[owner_id] = 0;
  - hold counter == MAX_HOLD-1, i.e. gnt has been high MAX_HOLD cycles.
- OWN, no release: gnt, owner_id and priority unchanged; hold counter increments. Requests from other requesters are ignored while locked.
- OWN, release:
  - priority <= gnt rotated left by 1 (owner becomes lowest priority).
  - next gnt = arb(req, rotated priority) if enable, else 0. Handoff is direct, with no idle bubble.
  - The releasing owner may be re-granted only if no other requester is active.
  - A new grant resets the hold counter to 0. A zero grant returns the FSM to IDLE.
- timeout:
  - Asserted for exactly one cycle after a release edge caused only by the hold limit (last = 0 and req[owner] = 1).
  - If last or a req drop coincides with the limit, it is a normal release and timeout = 0.
- enable = 0 during OWN: the current owner continues to its release; no new grant follows.
- last while IDLE is ignored. last is not qualified by requester; the team's bus rule allows only the owner to drive it.
- owner_id and gnt always update together. owner_id = index of the set bit of gnt.
- Hold counter width is $clog2(MAX_HOLD); it never wraps because release occurs at MAX_HOLD-1.

Test Plan (N=4, MAX_HOLD=4):
1. Reset with req=4'b1111, then enable=1 -> after first edge gnt=0001, owner_id=0. Pulse last -> next cycle gnt=0010, owner_id=1. Each subsequent last advances the grant to 0100, 1000, then 0001.
2. req=4'b0100 held, last=0 -> gnt=0100 for exactly 4 cycles, then timeout=1 for 1 cycle. With no other requester, gnt=0100 is re-granted at the same edge.
3. Owner 1 granted with req=4'b1010; drop req[1] -> next cycle gnt=1000, no timeout. Then req=0 with last -> gnt=0000, valid=0, owner_id stays 3.
4. Owner 2 granted, enable dropped to 0, req=4'b1111 -> owner 2 keeps gnt until last. Next cycle gnt=0000; it remains 0 until enable=1, then gnt=1000 (pointer at bit 3).
5. Owner 3 granted, assert rst for 1 cycle -> gnt=0, valid=0, timeout=0 after that edge. Release with req=4'b1111, enable=1 -> gnt=0001 (pointer restored to bit 0).
6. Limit coincident with last on cycle 4 of a hold -> normal release, timeout stays 0, and the grant moves to the next requester.
